mem_io_responder: RTL and testbench

//  Responder end of the CPU byte-wide memory bus (mem_a/mem_dout/mem_wr -> mem_din).

---
 rtl/mem_map_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mem_io_responder.sv | 136 +++++++++++++
 tb/tb_mem_io_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - shared CPU memory map: IO window decode, IO addresses, status bits
//
// Purpose: single source of truth for the IO window layout, shared by the CPU
//          side and the memory/IO responder.
// Contents:
//   IO_SEL_BITS         value of mem_a[17:16] that selects the IO window
//   IO_DATA / IO_STAT   UART data and status registers
//   IO_HALT             simulation halt register (store side of IO_STAT)
//   STAT_*_BIT          bit positions inside the status byte
//   acc_e / decode()    classification of a bus address
package mem_map_pkg;

  localparam logic [1:0]  IO_SEL_BITS = 2'b11;
  localparam logic [31:0] IO_DATA     = 32'h0003_0000;
  localparam logic [31:0] IO_STAT     = 32'h0003_0004;
  localparam logic [31:0] IO_HALT     = 32'h0003_0004;

  localparam int STAT_RX_BIT   = 0;  // holding register has a byte
  localparam int STAT_FULL_BIT = 1;  // TX FIFO nearly full

  typedef enum logic [1:0] {
    ACC_RAM     = 2'd0,
    ACC_IO_DATA = 2'd1,
    ACC_IO_STAT = 2'd2,
    ACC_IO_NONE = 2'd3
  } acc_e;

  // IO_HALT shares its address with IO_STAT, so loads see the status register
  // and stores are handled separately by the responder.
  function automatic acc_e decode(input logic [31:0] a);
    if (a[17:16] != IO_SEL_BITS) return ACC_RAM;
    else if (a == IO_DATA)       return ACC_IO_DATA;
    else if (a == IO_STAT)       return ACC_IO_STAT;
    else                         return ACC_IO_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push, pop, count, full and empty
//
// Purpose: TX byte queue between CPU IO stores and the UART.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_din     write request and data; ignored when full unless popping
//   i_pop             read request; ignored when empty
//   o_dout            head entry (valid when !o_empty)
//   o_count           occupancy, 0..DEPTH
//   o_full, o_empty   occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte bus responder: RAM plus UART TX FIFO / RX register
//
// Purpose: answers CPU loads/stores with one-cycle read latency, maps the IO
//          window onto a TX FIFO, an RX holding register and a halt flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global enable; low freezes all state
//   mem_a/mem_dout/mem_wr  CPU address, store byte, store strobe
//   mem_din             registered load byte (valid the cycle after the address)
//   io_buffer_full      TX FIFO nearly full (registered), stalls CPU IO stores
//   tx_data/tx_valid/tx_ready  TX FIFO head towards the UART
//   rx_data/rx_valid/rx_ready  incoming UART byte into the holding register
//   tx_overflow         sticky: an IO store was dropped on a full FIFO
//   sim_halt            sticky: CPU stored to IO_HALT
module mem_io_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int TX_ALMOST  = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        sim_halt
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]            r_ram [0:(2**ADDR_WIDTH)-1];
  logic [7:0]            r_rx_data;
  logic                  r_rx_full;
  logic [ADDR_WIDTH-1:0] w_idx;
  acc_e                  w_acc;
  logic                  w_ram_wr;
  logic                  w_tx_req;
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_tx_drop;
  logic                  w_halt_wr;
  logic                  w_rx_clear;
  logic                  w_rx_cap;
  logic [7:0]            w_stat;
  logic [7:0]            w_rd_byte;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_next;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  assign w_idx    = mem_a[ADDR_WIDTH-1:0];
  assign tx_valid = !w_fifo_empty;
  assign rx_ready = !r_rx_full;

  always_comb begin
    w_acc      = decode(mem_a);
    w_ram_wr   = rdy && mem_wr && (w_acc == ACC_RAM);
    w_tx_pop   = rdy && !w_fifo_empty && tx_ready;
    w_tx_req   = rdy && mem_wr && (w_acc == ACC_IO_DATA);
    // The FIFO is judged full after this cycle's pop.
    w_tx_push  = w_tx_req && (!w_fifo_full || w_tx_pop);
    w_tx_drop  = w_tx_req && !w_tx_push;
    w_halt_wr  = rdy && mem_wr && (mem_a == IO_HALT);
    w_rx_clear = rdy && !mem_wr && (w_acc == ACC_IO_DATA);
    w_rx_cap   = rdy && rx_valid && !r_rx_full;
    w_count_next = w_count + CW'(w_tx_push) - CW'(w_tx_pop);

    w_stat = 8'h00;
    w_stat[STAT_FULL_BIT] = io_buffer_full;
    w_stat[STAT_RX_BIT]   = r_rx_full;

    // RAM stores also return the old byte (read-before-write).
    w_rd_byte = 8'h00;
    case (w_acc)
      ACC_RAM:     w_rd_byte = r_ram[w_idx];
      ACC_IO_DATA: w_rd_byte = (!mem_wr && r_rx_full) ? r_rx_data : 8'h00;
      ACC_IO_STAT: w_rd_byte = mem_wr ? 8'h00 : w_stat;
      default:     w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_wr) r_ram[w_idx] <= mem_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      r_rx_data      <= 8'h00;
      r_rx_full      <= 1'b0;
      tx_overflow    <= 1'b0;
      sim_halt       <= 1'b0;
    end else if (rdy) begin
      mem_din        <= w_rd_byte;
      io_buffer_full <= (w_count_next >= CW'(TX_DEPTH - TX_ALMOST));
      // A capture can only happen while empty, so it wins over a clear.
      if (w_rx_cap) begin
        r_rx_data <= rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_clear) begin
        r_rx_full <= 1'b0;
      end
      if (w_tx_drop) tx_overflow <= 1'b1;
      if (w_halt_wr) sim_halt    <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_din   (mem_dout),
    .i_pop   (w_tx_pop),
    .o_dout  (tx_data),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        tx_overflow;
  logic        sim_halt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_STAT = 32'h0003_0004;
  localparam logic [31:0] A_OTHR = 32'h0003_0008;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_overflow    (tx_overflow),
    .sim_halt       (sim_halt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_a  = 32'h0;
    mem_wr = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
    step();
    bus_idle();
  endtask

  task automatic load(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; mem_a = 0; mem_dout = 0; mem_wr = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    #12;
    n_checks++;
    if ({mem_din, tx_valid, io_buffer_full, rx_ready, tx_overflow, sim_halt} !== {8'h00, 5'b00100}) begin
      $display("FAIL reset_state: got din=%h tv=%b ibf=%b rr=%b ov=%b halt=%b required 00 0 0 1 0 0",
               mem_din, tx_valid, io_buffer_full, rx_ready, tx_overflow, sim_halt);
      n_errors++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ram_latency();
    store(32'h100, 8'hA5);
    store(32'h101, 8'h5A);
    mem_a = 32'h100; mem_wr = 0;
    step();
    mem_a = 32'h101;
    n_checks++;
    if (mem_din !== 8'hA5) begin
      $display("FAIL ram_load_latency: got %h required a5", mem_din); n_errors++;
    end
    #2;
    n_checks++;
    if (mem_din !== 8'hA5) begin
      $display("FAIL ram_load_registered: got %h required a5", mem_din); n_errors++;
    end
    step();
    bus_idle();
    n_checks++;
    if (mem_din !== 8'h5A) begin
      $display("FAIL ram_load_next: got %h required 5a", mem_din); n_errors++;
    end
  endtask

  task automatic test_read_before_write();
    store(32'h20, 8'h77);
    store(32'h20, 8'h11);
    n_checks++;
    if (mem_din !== 8'h77) begin
      $display("FAIL rbw_old_byte: got %h required 77", mem_din); n_errors++;
    end
    load(32'h20);
    n_checks++;
    if (mem_din !== 8'h11) begin
      $display("FAIL rbw_new_byte: got %h required 11", mem_din); n_errors++;
    end
  endtask

  task automatic test_tx_fill_drain();
    tx_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      store(A_DATA, 8'(i));
      if (i == 5) begin
        n_checks++;
        if (io_buffer_full !== 1'b0) begin
          $display("FAIL ibf_after_5: got %b required 0", io_buffer_full); n_errors++;
        end
      end
      if (i == 6) begin
        n_checks++;
        if (io_buffer_full !== 1'b1) begin
          $display("FAIL ibf_after_6: got %b required 1", io_buffer_full); n_errors++;
        end
      end
      if (i == 8) begin
        n_checks++;
        if (tx_overflow !== 1'b0) begin
          $display("FAIL ovf_after_8: got %b required 0", tx_overflow); n_errors++;
        end
      end
      if (i == 9) begin
        n_checks++;
        if (tx_overflow !== 1'b1) begin
          $display("FAIL ovf_after_9: got %b required 1", tx_overflow); n_errors++;
        end
      end
    end
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        $display("FAIL drain_byte_%0d: got tv=%b data=%h required 1 %h", i, tx_valid, tx_data, 8'(i));
        n_errors++;
      end
      step();
    end
    tx_ready = 0;
    n_checks++;
    if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      $display("FAIL drain_empty: got tv=%b ibf=%b required 0 0", tx_valid, io_buffer_full); n_errors++;
    end
  endtask

  task automatic test_full_push_pop();
    #2 rst_n = 0;
    #2 rst_n = 1;
    step();
    tx_ready = 0;
    for (int i = 0; i < 8; i++) store(A_DATA, 8'h41 + 8'(i));
    n_checks++;
    if (io_buffer_full !== 1'b1 || tx_overflow !== 1'b0) begin
      $display("FAIL full_setup: got ibf=%b ov=%b required 1 0", io_buffer_full, tx_overflow); n_errors++;
    end
    tx_ready = 1;
    n_checks++;
    if (tx_data !== 8'h41) begin
      $display("FAIL full_head: got %h required 41", tx_data); n_errors++;
    end
    store(A_DATA, 8'h49);
    n_checks++;
    if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1) begin
      $display("FAIL full_push_pop: got ov=%b ibf=%b required 0 1", tx_overflow, io_buffer_full); n_errors++;
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h42 + 8'(i)) begin
        $display("FAIL full_drain_%0d: got tv=%b data=%h required 1 %h", i, tx_valid, tx_data, 8'h42 + 8'(i));
        n_errors++;
      end
      step();
    end
    tx_ready = 0;
    n_checks++;
    if (tx_valid !== 1'b0) begin
      $display("FAIL full_drain_end: got tv=%b required 0", tx_valid); n_errors++;
    end
  endtask

  task automatic test_rx_and_io();
    n_checks++;
    if (rx_ready !== 1'b1) begin
      $display("FAIL rx_idle_ready: got %b required 1", rx_ready); n_errors++;
    end
    rx_valid = 1; rx_data = 8'h3C;
    step();
    rx_valid = 1; rx_data = 8'h99;  // arrives while full: must be ignored
    step();
    rx_valid = 0;
    load(A_STAT);
    n_checks++;
    if (mem_din !== 8'h01 || rx_ready !== 1'b0) begin
      $display("FAIL rx_stat: got din=%h rr=%b required 01 0", mem_din, rx_ready); n_errors++;
    end
    load(A_OTHR);
    n_checks++;
    if (mem_din !== 8'h00) begin
      $display("FAIL io_other_load: got %h required 00", mem_din); n_errors++;
    end
    load(A_DATA);
    n_checks++;
    if (mem_din !== 8'h3C || rx_ready !== 1'b1) begin
      $display("FAIL rx_data_load: got din=%h rr=%b required 3c 1", mem_din, rx_ready); n_errors++;
    end
    store(32'h30, 8'hC3);
    load(32'h30);
    load(A_DATA);
    n_checks++;
    if (mem_din !== 8'h00) begin
      $display("FAIL rx_empty_load: got %h required 00", mem_din); n_errors++;
    end
    mem_a = A_DATA; mem_wr = 0; rx_valid = 1; rx_data = 8'h5E;
    step();
    bus_idle(); rx_valid = 0;
    n_checks++;
    if (mem_din !== 8'h00 || rx_ready !== 1'b0) begin
      $display("FAIL rx_same_cycle: got din=%h rr=%b required 00 0", mem_din, rx_ready); n_errors++;
    end
    load(A_DATA);
    n_checks++;
    if (mem_din !== 8'h5E) begin
      $display("FAIL rx_same_cycle_byte: got %h required 5e", mem_din); n_errors++;
    end
    store(A_OTHR, 8'h77);
    n_checks++;
    if (tx_valid !== 1'b0 || sim_halt !== 1'b0) begin
      $display("FAIL io_other_store: got tv=%b halt=%b required 0 0", tx_valid, sim_halt); n_errors++;
    end
    store(A_STAT, 8'h01);
    n_checks++;
    if (sim_halt !== 1'b1 || tx_valid !== 1'b0) begin
      $display("FAIL halt_store: got halt=%b tv=%b required 1 0", sim_halt, tx_valid); n_errors++;
    end
  endtask

  task automatic test_rdy_and_async_reset();
    tx_ready = 0;
    for (int i = 1; i <= 9; i++) store(A_DATA, 8'(i));
    rx_valid = 1; rx_data = 8'h66;
    step();
    rx_valid = 0;
    load(A_STAT);
    n_checks++;
    if (mem_din !== 8'h03) begin
      $display("FAIL stat_full_rx: got %h required 03", mem_din); n_errors++;
    end
    load(32'h100);
    rdy = 0; mem_a = 32'h20; mem_wr = 1; mem_dout = 8'hEE; tx_ready = 1;
    rx_valid = 1; rx_data = 8'h12;
    step();
    step();
    n_checks++;
    if (mem_din !== 8'hA5 || tx_data !== 8'h01 || rx_ready !== 1'b0 || io_buffer_full !== 1'b1) begin
      $display("FAIL rdy_hold: got din=%h data=%h rr=%b ibf=%b required a5 01 0 1",
               mem_din, tx_data, rx_ready, io_buffer_full);
      n_errors++;
    end
    rdy = 1; rx_valid = 0; bus_idle();
    step();
    n_checks++;
    if (tx_data !== 8'h02) begin
      $display("FAIL drain_resume: got %h required 02", tx_data); n_errors++;
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({mem_din, tx_valid, io_buffer_full, rx_ready, tx_overflow, sim_halt} !== {8'h00, 5'b00100}) begin
      $display("FAIL async_reset_drain: got din=%h tv=%b ibf=%b rr=%b ov=%b halt=%b required 00 0 0 1 0 0",
               mem_din, tx_valid, io_buffer_full, rx_ready, tx_overflow, sim_halt);
      n_errors++;
    end
    rst_n = 1; tx_ready = 0;
    step();
    store(A_DATA, 8'hAB);
    rx_valid = 1; rx_data = 8'h44;
    step();
    rx_valid = 0;
    rdy = 0;
    #3 rst_n = 0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || mem_din !== 8'h00) begin
      $display("FAIL async_reset_rdy0: got tv=%b rr=%b din=%h required 0 1 00", tx_valid, rx_ready, mem_din);
      n_errors++;
    end
    rst_n = 1; rdy = 1;
    load(32'h20);
    n_checks++;
    if (mem_din !== 8'h11) begin
      $display("FAIL ram_retained_20: got %h required 11", mem_din); n_errors++;
    end
    load(32'h100);
    n_checks++;
    if (mem_din !== 8'hA5) begin
      $display("FAIL ram_retained_100: got %h required a5", mem_din); n_errors++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram_latency();
    test_read_before_write();
    test_tx_fill_drain();
    test_full_push_pop();
    test_rx_and_io();
    test_rdy_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
